// File: rtl/uarch_rst_seq.sv
// fence.t micro-reset sequencer: flush caches, drain handshaked channels, pad to a
// selectable timing source, then hold the micro-architectural reset for a fixed time.
module uarch_rst_seq #(
  parameter int unsigned VLEN            = 64,
  parameter int unsigned NrDrainCh       = 2,
  parameter int unsigned DrainIdleCycles = 16,
  parameter int unsigned RstCycles       = 16,
  parameter int unsigned CacheInitCycles = 3,
  parameter int unsigned PadWidth        = 32,
  parameter int unsigned NrPadSrc        = 2,
  localparam int unsigned SelW = (NrPadSrc > 1) ? $clog2(NrPadSrc) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 fence_t_i,
  input  logic [VLEN-1:0]      pc_commit_i,
  input  logic [VLEN-1:0]      boot_addr_i,
  output logic [VLEN-1:0]      rst_addr_o,
  output logic                 flush_o,
  input  logic                 flush_ack_i,
  input  logic [NrDrainCh-1:0] busy_i,
  input  logic [NrDrainCh-1:0] drain_mask_i,
  input  logic [PadWidth-1:0]  pad_i,
  input  logic [SelW-1:0]      pad_src_sel_i,
  input  logic [NrPadSrc-1:0]  pad_trig_i,
  output logic [PadWidth-1:0]  ceil_o,
  output logic                 halt_o,
  output logic                 stall_o,
  output logic                 rst_uarch_no,
  output logic                 cache_init_no,
  output logic                 done_o
);

  localparam int unsigned DrW = $clog2(DrainIdleCycles + 1);
  localparam int unsigned RcW = (RstCycles > 1) ? $clog2(RstCycles) : 1;
  localparam logic [DrW-1:0] DrMax = DrW'(DrainIdleCycles);
  localparam logic [RcW-1:0] RcMax = RcW'(RstCycles - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    DRAIN = 3'd2,
    PAD   = 3'd3,
    RST   = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic [DrW-1:0]             drain_cnt_q, drain_cnt_d;
  logic [PadWidth-1:0]        pad_cnt_q, pad_cnt_d;
  logic [PadWidth-1:0]        ceil_q, ceil_d;
  logic [NrPadSrc-1:0]        trig_q, trig_d;
  logic [RcW-1:0]             rst_cnt_q, rst_cnt_d;
  logic [VLEN-1:0]            rst_addr_q, rst_addr_d;
  logic [CacheInitCycles-1:0] ci_sr_q, ci_sr_d;
  logic                       done_q, done_d;
  logic [(2**SelW)-1:0]       rise_vec;
  logic                       busy_any, trig_rise;

  // Out-of-range selects land on the zero-padded upper entries and never fire.
  always_comb begin
    rise_vec                = '0;
    rise_vec[NrPadSrc-1:0]  = pad_trig_i & ~trig_q;
    trig_rise               = rise_vec[pad_src_sel_i];
    busy_any                = |(busy_i & ~drain_mask_i);
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    rst_addr_d  = rst_addr_q;
    ceil_d      = ceil_q;
    done_d      = 1'b0;
    trig_d      = pad_trig_i;

    if (busy_any)                drain_cnt_d = '0;
    else if (drain_cnt_q == DrMax) drain_cnt_d = drain_cnt_q;
    else                         drain_cnt_d = drain_cnt_q + DrW'(1);

    if (trig_rise)               pad_cnt_d = pad_i;
    else if (pad_cnt_q != '0)    pad_cnt_d = pad_cnt_q - PadWidth'(1);
    else                         pad_cnt_d = pad_cnt_q;

    ci_sr_d[0] = (state_q == RST);
    for (int i = 1; i < CacheInitCycles; i++) ci_sr_d[i] = ci_sr_q[i-1];

    case (state_q)
      IDLE: if (fence_t_i) begin
        state_d    = FLUSH;
        rst_addr_d = pc_commit_i + VLEN'(4);
        ceil_d     = '0;
      end
      FLUSH: if (flush_ack_i) state_d = DRAIN;
      DRAIN: if (drain_cnt_q == DrMax) begin
        state_d = PAD;
        ceil_d  = (pad_cnt_q == '0) ? '0 : pad_i - pad_cnt_q;
      end
      PAD: if (pad_cnt_q == '0) begin
        state_d   = RST;
        rst_cnt_d = '0;
      end
      RST: if (rst_cnt_q == RcMax) begin
        state_d   = IDLE;
        rst_cnt_d = '0;
        done_d    = 1'b1;
      end else begin
        rst_cnt_d = rst_cnt_q + RcW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      pad_cnt_q   <= '0;
      ceil_q      <= '0;
      trig_q      <= '0;
      rst_cnt_q   <= '0;
      rst_addr_q  <= boot_addr_i;
      ci_sr_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      pad_cnt_q   <= pad_cnt_d;
      ceil_q      <= ceil_d;
      trig_q      <= trig_d;
      rst_cnt_q   <= rst_cnt_d;
      rst_addr_q  <= rst_addr_d;
      ci_sr_q     <= ci_sr_d;
      done_q      <= done_d;
    end
  end

  assign rst_addr_o    = rst_addr_q;
  assign ceil_o        = ceil_q;
  assign flush_o       = (state_q == FLUSH);
  assign halt_o        = (state_q != IDLE);
  assign stall_o       = (state_q != IDLE);
  assign rst_uarch_no  = (state_q != RST);
  assign cache_init_no = |ci_sr_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_uarch_rst_seq.sv
// Scoreboard bench for uarch_rst_seq: default instance plus a minimal-parameter instance.
module tb_uarch_rst_seq;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fence, ack;
  logic [63:0] pc, boot;
  logic [1:0]  busy, mask, trig;
  logic [31:0] pad;
  logic [0:0]  sel;
  logic [63:0] rst_addr_o;
  logic [31:0] ceil_o;
  logic        flush_o, halt_o, stall_o, rst_uarch_no, cache_init_no, done_o;

  logic        fence2, ack2;
  logic [63:0] pc2;
  logic [0:0]  busy2, mask2, trig2, sel2;
  logic [63:0] addr2;
  logic [31:0] ceil2;
  logic        flush2, halt2, stall2, rstn2, ci2, done2;

  always #5 clk = ~clk;

  uarch_rst_seq dut (
    .clk_i(clk), .rst_ni(rst_ni), .fence_t_i(fence), .pc_commit_i(pc), .boot_addr_i(boot),
    .rst_addr_o(rst_addr_o), .flush_o(flush_o), .flush_ack_i(ack), .busy_i(busy),
    .drain_mask_i(mask), .pad_i(pad), .pad_src_sel_i(sel), .pad_trig_i(trig), .ceil_o(ceil_o),
    .halt_o(halt_o), .stall_o(stall_o), .rst_uarch_no(rst_uarch_no),
    .cache_init_no(cache_init_no), .done_o(done_o)
  );

  uarch_rst_seq #(.NrDrainCh(1), .DrainIdleCycles(1), .RstCycles(1), .CacheInitCycles(1),
                  .NrPadSrc(1)) dut2 (
    .clk_i(clk), .rst_ni(rst_ni), .fence_t_i(fence2), .pc_commit_i(pc2), .boot_addr_i(boot),
    .rst_addr_o(addr2), .flush_o(flush2), .flush_ack_i(ack2), .busy_i(busy2),
    .drain_mask_i(mask2), .pad_i(pad), .pad_src_sel_i(sel2), .pad_trig_i(trig2), .ceil_o(ceil2),
    .halt_o(halt2), .stall_o(stall2), .rst_uarch_no(rstn2),
    .cache_init_no(ci2), .done_o(done2)
  );

  typedef struct {
    logic [63:0] addr;
    logic [31:0] ceil;
    int          flush, mid, rst;
  } exp_t;

  exp_t q0[$], q1[$];
  int   cq0[$], cq1[$];
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: per-cycle length counters, checked against the queued expectation on done.
  int n_h[2], n_f[2], n_r[2], n_s[2], n_c[2];
  bit pci[2], pdn[2];
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic h, f, r, s, c, d;
      logic [63:0] a;
      logic [31:0] cl;
      exp_t e;
      int   ce;
      if (k == 0) begin
        h = halt_o; f = flush_o; r = rst_uarch_no; s = stall_o; c = cache_init_no; d = done_o;
        a = rst_addr_o; cl = ceil_o;
      end else begin
        h = halt2; f = flush2; r = rstn2; s = stall2; c = ci2; d = done2; a = addr2; cl = ceil2;
      end
      if (!rst_ni) begin
        n_h[k] = 0; n_f[k] = 0; n_r[k] = 0; n_s[k] = 0; n_c[k] = 0; pci[k] = 0; pdn[k] = 0;
      end else begin
        if (pdn[k]) chk($sformatf("d%0d_done_pulse", k), d, 1'b0);
        if (h) n_h[k]++;
        if (f) n_f[k]++;
        if (!r) n_r[k]++;
        if (s) n_s[k]++;
        if (c) n_c[k]++;
        else if (pci[k]) begin
          chk($sformatf("d%0d_ci_pending", k), ((k == 0) ? cq0.size() : cq1.size()) > 0, 1'b1);
          if ((k == 0) ? cq0.size() > 0 : cq1.size() > 0) begin
            ce = (k == 0) ? cq0.pop_front() : cq1.pop_front();
            chk($sformatf("d%0d_ci_len", k), n_c[k], ce);
          end
          n_c[k] = 0;
        end
        pci[k] = c;
        if (d) begin
          chk($sformatf("d%0d_exp_pending", k), ((k == 0) ? q0.size() : q1.size()) > 0, 1'b1);
          if ((k == 0) ? q0.size() > 0 : q1.size() > 0) begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("d%0d_rst_addr", k), a, e.addr);
            chk($sformatf("d%0d_ceil", k), cl, e.ceil);
            chk($sformatf("d%0d_flush_len", k), n_f[k], e.flush);
            chk($sformatf("d%0d_drain_pad_len", k), n_h[k] - n_f[k] - n_r[k], e.mid);
            chk($sformatf("d%0d_rst_len", k), n_r[k], e.rst);
            chk($sformatf("d%0d_stall_len", k), n_s[k], e.flush + e.mid + e.rst);
          end
          n_h[k] = 0; n_f[k] = 0; n_r[k] = 0; n_s[k] = 0;
        end
        pdn[k] = d;
      end
    end
  end

  // Starts a sequence on the default instance; returns one cycle after the flush ack.
  task automatic issue(input logic [63:0] p, input int ack_delay, input int trig_at,
                       input logic [1:0] trig_val, input bit hold, input logic [1:0] busy_after);
    busy = 2'b01; fence = 1'b1; pc = p;
    for (int i = 1; i <= ack_delay; i++) begin
      @(posedge clk); #1;
      if (!hold) fence = 1'b0;
      if (i == trig_at) trig = trig_val;
      if (i == ack_delay) begin ack = 1'b1; busy = busy_after; end
    end
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic wait_done(input int k, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (((k == 0) ? !done_o : !done2) && n < 3000);
    chk({tag, "_done_seen"}, (k == 0) ? done_o : done2, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_rst_addr"}, rst_addr_o, boot);
    chk({tag, "_ceil"}, ceil_o, 32'd0);
    chk({tag, "_flush"}, flush_o, 1'b0);
    chk({tag, "_halt"}, halt_o, 1'b0);
    chk({tag, "_stall"}, stall_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_cache_init_n"}, cache_init_no, 1'b0);
    chk({tag, "_rst_uarch_n"}, rst_uarch_no, 1'b1);
  endtask

  task automatic push0(input logic [63:0] a, input logic [31:0] c, input int f, input int m);
    exp_t e;
    e.addr = a; e.ceil = c; e.flush = f; e.mid = m; e.rst = 16;
    q0.push_back(e);
    cq0.push_back(16 + 3 - 1);
  endtask

  initial begin
    exp_t e;
    int   n;
    fence = 0; ack = 0; pc = '0; boot = 64'h1000_0000; busy = 2'b01; mask = 2'b00;
    trig = 2'b00; pad = 32'd0; sel = 1'b1;
    fence2 = 0; ack2 = 0; pc2 = '0; busy2 = 1'b0; mask2 = 1'b0; trig2 = 1'b0; sel2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_rst_vals("por");
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Basic: 5-cycle flush, 16-cycle drain, 1-cycle pad, no trigger.
    push0(64'h8000_1004, 32'd0, 5, 17);
    issue(64'h8000_1000, 5, 0, 2'b00, 1'b0, 2'b00);
    wait_done(0, "basic");

    // Channel 1 keeps toggling every 10 cycles; masking it lets the drain finish.
    push0(64'h2004, 32'd0, 3, 79);
    issue(64'h2000, 3, 0, 2'b00, 1'b0, 2'b10);
    for (int i = 0; i < 6; i++) begin
      repeat (10) @(posedge clk);
      #1 busy[1] = ~busy[1];
    end
    @(posedge clk); #1 mask = 2'b10;
    wait_done(0, "mask");
    mask = 2'b00;

    // Selected trigger loads pad 41 cycles before drain exit -> 40 consumed, 60 left.
    pad = 32'd100;
    push0(64'h3004, 32'd40, 30, 76);
    issue(64'h3000, 30, 5, 2'b10, 1'b0, 2'b00);
    wait_done(0, "pad_sel1");
    trig = 2'b00;
    // Edge on the unselected source does nothing.
    push0(64'h3104, 32'd0, 30, 17);
    issue(64'h3100, 30, 5, 2'b01, 1'b0, 2'b00);
    wait_done(0, "pad_sel0");
    trig = 2'b00;

    // PC wrap, fence held: restart only once back in IDLE, on the following cycle.
    push0(64'h0, 32'd0, 5, 17);
    push0(64'h0, 32'd0, 2, 17);
    issue(64'hFFFF_FFFF_FFFF_FFFC, 5, 0, 2'b00, 1'b1, 2'b00);
    wait_done(0, "wrap1");
    fence = 1'b0; busy = 2'b01;
    @(negedge clk) chk("restart_next_cycle", halt_o, 1'b1);
    @(posedge clk); #1 ack = 1'b1; busy = 2'b00;
    @(posedge clk); #1 ack = 1'b0;
    wait_done(0, "wrap2");

    // Abort in RST cycle 7 of a sequence that had a nonzero ceiling.
    issue(64'h5000, 30, 5, 2'b10, 1'b0, 2'b00);
    n = 0;
    do begin @(negedge clk); n++; end while (rst_uarch_no && n < 500);
    chk("abort_rst_entry", rst_uarch_no, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst_ni = 1'b0; trig = 2'b00;
    #1 chk_rst_vals("abort");
    @(negedge clk) rst_ni = 1'b1;
    @(posedge clk); #1;
    push0(64'h6004, 32'd0, 5, 17);
    issue(64'h6000, 5, 0, 2'b00, 1'b0, 2'b00);
    wait_done(0, "post_abort");

    // Minimal-parameter instance: 1-cycle drain, 1-cycle reset, 1-cycle cache init.
    e.addr = 64'h59; e.ceil = 32'd0; e.flush = 3; e.mid = 2; e.rst = 1;
    q1.push_back(e);
    cq1.push_back(1);
    busy2 = 1'b1; fence2 = 1'b1; pc2 = 64'h55;
    @(posedge clk); #1 fence2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 ack2 = 1'b1; busy2 = 1'b0;
    @(posedge clk); #1 ack2 = 1'b0;
    wait_done(1, "small");

    repeat (10) @(posedge clk);
    #1;
    chk("q0_drained", q0.size() + cq0.size(), 0);
    chk("q1_drained", q1.size() + cq1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
